// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle: the access unit is master (req/we/addr/be/wdata), memory is slave (rdata/ack).
interface mem_access_unit_if #(
  parameter int ADDR_W = 10
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: IDLE -> REQ(n, ack or TIMEOUT) -> DONE, stalling the pipe until DONE.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module mem_access_unit #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memread,
  input  logic                 memwrite,
  input  logic [1:0]           length,
  input  logic                 sign,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic                 bus_err,
  output logic                 misalign,
  mem_access_unit_if.master    dmem
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              load_q, load_d;
  logic [1:0]        len_q, len_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;

  logic              mis;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign mis = ((length == 2'b01) && addr[0]) || (length[1] && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Half ignores addr[0] and word ignores addr[1:0]: forced-aligned lanes.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata;
    if (length == 2'b00) begin
      be_new    = 4'b0001 << addr[1:0];
      wdata_new = {4{wdata[7:0]}};
    end else if (length == 2'b01) begin
      be_new    = 4'b0011 << {addr[1], 1'b0};
      wdata_new = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    shifted  = dmem.dmem_rdata;
    if (len_q == 2'b00) begin
      shifted = dmem.dmem_rdata >> {off_q, 3'b000};
    end else if (len_q == 2'b01) begin
      shifted = dmem.dmem_rdata >> {off_q[1], 4'b0000};
    end
    load_val = shifted;
    if (len_q == 2'b00) begin
      load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
    end else if (len_q == 2'b01) begin
      load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    len_d      = len_q;
    sign_d     = sign_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (memread || memwrite) begin
          we_d    = memwrite;
          addr_d  = addr[ADDR_W+1:2];
          be_d    = be_new;
          wdata_d = wdata_new;
          load_d  = memread & ~memwrite;
          len_d   = length;
          sign_d  = sign;
          off_d   = addr[1:0];
          cnt_d   = '0;
          if (mis) begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (load_q) begin
            rdata_d = load_val;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Results stay visible for the whole DONE cycle, then clear on the way to IDLE.
        rdata_d    = '0;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      len_q      <= '0;
      sign_q     <= 1'b0;
      off_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      len_q      <= len_d;
      sign_q     <= sign_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  // Reset gates the IDLE request term so stall drops at once even with a memory op pending.
  assign stall = ~reset & (((state_q == IDLE) & (memread | memwrite)) | (state_q == REQ));

  assign rdata           = rdata_q;
  assign bus_err         = bus_err_q;
  assign misalign        = misalign_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives on the falling edge, checks 1 time unit later.
module tb_mem_access_unit;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, sign;
  logic [1:0]  length;
  logic [31:0] addr, wdata, rdata;
  logic        stall, bus_err, misalign;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_cycles;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .length   (length),
    .sign     (sign),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .bus_err  (bus_err),
    .misalign (misalign),
    .dmem     (dmem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd, input logic wr, input logic [1:0] len,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    memread  = rd;
    memwrite = wr;
    length   = len;
    sign     = sg;
    addr     = a;
    wdata    = wd;
    #1;
  endtask

  task automatic ack_next(input logic [31:0] d);
    dmem.dmem_rdata = d;
    dmem.dmem_ack   = 1'b1;
    @(negedge clk);
    dmem.dmem_ack   = 1'b0;
    memread         = 1'b0;
    memwrite        = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    memread = 1'b0; memwrite = 1'b0; length = 2'b00; sign = 1'b0;
    addr = '0; wdata = '0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    #12;
    chk("rst_stall",    stall,         32'd0);
    chk("rst_req",      dmem.dmem_req, 32'd0);
    chk("rst_rdata",    rdata,         32'd0);
    chk("rst_bus_err",  bus_err,       32'd0);
    chk("rst_misalign", misalign,      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Non-memory instruction with a stray ack.
    @(negedge clk);
    dmem.dmem_ack = 1'b1;
    #1;
    chk("nomem_stall", stall, 32'd0);
    @(negedge clk);
    dmem.dmem_ack = 1'b0;
    #1;
    chk("stray_ack_req", dmem.dmem_req, 32'd0);
    chk("stray_ack_stall", stall, 32'd0);

    // Word load at 0x104, ack on first REQ cycle.
    start(1, 0, 2'b10, 0, 32'h0000_0104, 0);
    chk("t1_idle_stall", stall, 32'd1);
    @(negedge clk); #1;
    chk("t1_req",       dmem.dmem_req,  32'd1);
    chk("t1_req_stall", stall,          32'd1);
    chk("t1_addr",      dmem.dmem_addr, 32'h041);
    chk("t1_be",        dmem.dmem_be,   32'hF);
    chk("t1_we",        dmem.dmem_we,   32'd0);
    ack_next(32'hDEAD_BEEF);
    chk("t1_done_stall", stall,         32'd0);
    chk("t1_done_req",   dmem.dmem_req, 32'd0);
    chk("t1_rdata",      rdata,         32'hDEAD_BEEF);

    // Signed byte load at 0x103.
    start(1, 0, 2'b00, 1, 32'h0000_0103, 0);
    chk("t2_idle_rdata_clr", rdata, 32'd0);
    @(negedge clk); #1;
    chk("t2_be",   dmem.dmem_be,   32'b1000);
    chk("t2_addr", dmem.dmem_addr, 32'h040);
    ack_next(32'h80FF_0000);
    chk("t2_rdata_s", rdata, 32'hFFFF_FF80);

    // Same byte, zero-extended.
    start(1, 0, 2'b00, 0, 32'h0000_0103, 0);
    @(negedge clk); #1;
    ack_next(32'h80FF_0000);
    chk("t2_rdata_u", rdata, 32'h0000_0080);

    // Half store at 0x202, ack on second REQ cycle.
    start(0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD);
    @(negedge clk); #1;
    chk("t3_we",    dmem.dmem_we,    32'd1);
    chk("t3_be",    dmem.dmem_be,    32'b1100);
    chk("t3_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    chk("t3_addr",  dmem.dmem_addr,  32'h080);
    @(negedge clk); #1;
    chk("t3_wait_stall", stall,         32'd1);
    chk("t3_wait_req",   dmem.dmem_req, 32'd1);
    ack_next(32'h0);
    chk("t3_done_stall", stall, 32'd0);
    chk("t3_rdata",      rdata, 32'd0);

    // Timeout: no ack at all.
    dmem.dmem_rdata = 32'h5555_5555;
    start(1, 0, 2'b10, 0, 32'h0000_0010, 0);
    req_cycles = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      @(negedge clk); #1;
      if (dmem.dmem_req) req_cycles++;
    end
    chk("t4_req_cycles", req_cycles, 32'd16);
    chk("t4_stall",      stall,      32'd0);
    chk("t4_bus_err",    bus_err,    32'd1);
    chk("t4_rdata",      rdata,      32'd0);
    memread = 1'b0;

    // Next op after timeout: signed half load at 0x006.
    start(1, 0, 2'b01, 1, 32'h0000_0006, 0);
    chk("t4_berr_clr", bus_err, 32'd0);
    @(negedge clk); #1;
    chk("t4b_be",   dmem.dmem_be,   32'b1100);
    chk("t4b_addr", dmem.dmem_addr, 32'h001);
    ack_next(32'h8001_1234);
    chk("t4b_rdata", rdata,   32'hFFFF_8001);
    chk("t4b_berr",  bus_err, 32'd0);

    // memread and memwrite both set: a store, rdata stays 0.
    start(1, 1, 2'b10, 0, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk); #1;
    chk("t5_we",    dmem.dmem_we,    32'd1);
    chk("t5_wdata", dmem.dmem_wdata, 32'hCAFE_F00D);
    ack_next(32'h1234_5678);
    chk("t5_rdata", rdata, 32'd0);

    // Word access at 0x106: forced-aligned by default, trapped with the macro.
    start(1, 0, 2'b10, 0, 32'h0000_0106, 0);
    chk("t6_idle_stall", stall, 32'd1);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    memread = 1'b0;
    #1;
    chk("t6_no_req",   dmem.dmem_req, 32'd0);
    chk("t6_stall",    stall,         32'd0);
    chk("t6_misalign", misalign,      32'd1);
    chk("t6_rdata",    rdata,         32'd0);
`else
    @(negedge clk); #1;
    chk("t6_addr", dmem.dmem_addr, 32'h041);
    chk("t6_be",   dmem.dmem_be,   32'hF);
    ack_next(32'hA1B2_C3D4);
    chk("t6_rdata",    rdata,    32'hA1B2_C3D4);
    chk("t6_misalign", misalign, 32'd0);
`endif

    // Reset in the third REQ cycle, then a clean load.
    start(1, 0, 2'b10, 0, 32'h0000_03FC, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t7_rst_req",   dmem.dmem_req, 32'd0);
    chk("t7_rst_stall", stall,         32'd0);
    chk("t7_rst_rdata", rdata,         32'd0);
    @(negedge clk);
    reset   = 1'b0;
    memread = 1'b0;
    start(1, 0, 2'b10, 0, 32'h0000_03FC, 0);
    @(negedge clk); #1;
    chk("t7_req",  dmem.dmem_req,  32'd1);
    chk("t7_addr", dmem.dmem_addr, 32'h0FF);
    ack_next(32'h1122_3344);
    chk("t7_rdata", rdata, 32'h1122_3344);
    chk("t7_stall", stall, 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 50000");
    $fatal(1);
  end
endmodule
